alu_issue_ctrl: RTL and testbench

- Sequential command front-end that sits directly upstream of the 8-bit ripple ALU and also captures its outputs.
- Accepts an (opcode, operand A, operand B) command over a valid/ready handshake and decodes the opcode to Ainvert/Binvert/op.
- Drives the ALU from registered operands, then captures result/zero/overflow into a held response with valid/ready backpressure.

---
 rtl/alu_issue_ctrl_pkg.sv | 25 ++
 rtl/alu_issue_ctrl_func_decode.sv | 50 +++++
 rtl/alu_issue_ctrl.sv | 131 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared encodings for the ALU issue front-end: opcode map, ALU op field and FSM states.
package alu_pkg;

   localparam logic [2:0] FUNC_AND     = 3'd0;
   localparam logic [2:0] FUNC_OR      = 3'd1;
   localparam logic [2:0] FUNC_ADD     = 3'd2;
   localparam logic [2:0] FUNC_SUB     = 3'd3;
   localparam logic [2:0] FUNC_SLT     = 3'd4;
   localparam logic [2:0] FUNC_NOR     = 3'd5;
   localparam logic [2:0] FUNC_NAND    = 3'd6;
   localparam logic [2:0] FUNC_ILLEGAL = 3'd7;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SLT = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

endpackage

// File: rtl/alu_issue_ctrl_func_decode.sv
// Combinational opcode decoder: func -> ALU control lines plus arithmetic/illegal flags.
module alu_func_decode
   import alu_pkg::*;
(
   input  logic [2:0] func,
   output logic       ainvert,
   output logic       binvert,
   output logic [1:0] op,
   output logic       is_arith,
   output logic       is_illegal
);

   always_comb begin
      ainvert    = 1'b0;
      binvert    = 1'b0;
      op         = OP_AND;
      is_arith   = 1'b0;
      is_illegal = 1'b0;
      unique case (func)
         FUNC_AND:  op = OP_AND;
         FUNC_OR:   op = OP_OR;
         FUNC_ADD: begin
            op       = OP_ADD;
            is_arith = 1'b1;
         end
         FUNC_SUB: begin
            binvert  = 1'b1;
            op       = OP_ADD;
            is_arith = 1'b1;
         end
         FUNC_SLT: begin
            binvert = 1'b1;
            op      = OP_SLT;
         end
         // De Morgan: ~A & ~B is NOR, ~A | ~B is NAND
         FUNC_NOR: begin
            ainvert = 1'b1;
            binvert = 1'b1;
            op      = OP_AND;
         end
         FUNC_NAND: begin
            ainvert = 1'b1;
            binvert = 1'b1;
            op      = OP_OR;
         end
         default: is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command front-end for the 8-bit ripple ALU: issues registered operands, captures a held response.
// Optional sticky overflow flag enabled by defining ALU_ISSUE_STICKY_OVF_EN.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W = 8
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_func,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   output logic [DATA_W-1:0] alu_src1,
   output logic [DATA_W-1:0] alu_src2,
   output logic              alu_ainvert,
   output logic              alu_binvert,
   output logic [1:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_overflow,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic              rsp_overflow,
   output logic              rsp_err,
   input  logic              sticky_clr,
   output logic              ovf_sticky
);

   state_t     state;
   logic       is_arith_q;
   logic       is_illegal_q;

   logic       dec_ainvert;
   logic       dec_binvert;
   logic [1:0] dec_op;
   logic       dec_is_arith;
   logic       dec_is_illegal;
   logic       capture_ovf;

   alu_func_decode u_decode (
      .func       (cmd_func),
      .ainvert    (dec_ainvert),
      .binvert    (dec_binvert),
      .op         (dec_op),
      .is_arith   (dec_is_arith),
      .is_illegal (dec_is_illegal)
   );

   // Gated by rst so a requester never sees ready while reset is held
   assign cmd_ready   = (state == S_IDLE) && !rst;
   assign capture_ovf = is_arith_q && !is_illegal_q && alu_overflow;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         is_arith_q   <= 1'b0;
         is_illegal_q <= 1'b0;
         alu_src1     <= '0;
         alu_src2     <= '0;
         alu_ainvert  <= 1'b0;
         alu_binvert  <= 1'b0;
         alu_op       <= OP_AND;
         rsp_valid    <= 1'b0;
         rsp_result   <= '0;
         rsp_zero     <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_err      <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  is_arith_q   <= dec_is_arith;
                  is_illegal_q <= dec_is_illegal;
                  alu_src1     <= dec_is_illegal ? '0 : cmd_a;
                  alu_src2     <= dec_is_illegal ? '0 : cmd_b;
                  alu_ainvert  <= dec_ainvert;
                  alu_binvert  <= dec_binvert;
                  alu_op       <= dec_op;
                  state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               rsp_result   <= is_illegal_q ? '0 : alu_result;
               rsp_zero     <= is_illegal_q ? 1'b0 : alu_zero;
               rsp_overflow <= capture_ovf;
               rsp_err      <= is_illegal_q;
               rsp_valid    <= 1'b1;
               alu_src1     <= '0;
               alu_src2     <= '0;
               alu_ainvert  <= 1'b0;
               alu_binvert  <= 1'b0;
               alu_op       <= OP_AND;
               state        <= S_HOLD;
            end
            S_HOLD: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef ALU_ISSUE_STICKY_OVF_EN
   // Set is checked first so a same-edge clear loses
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_sticky <= 1'b0;
      end else if (state == S_CAPTURE && capture_ovf) begin
         ovf_sticky <= 1'b1;
      end else if (sticky_clr) begin
         ovf_sticky <= 1'b0;
      end
   end
`else
   logic unused_sticky_clr;
   assign unused_sticky_clr = sticky_clr;
   assign ovf_sticky        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ripple-ALU model and response scoreboard.
module tb_alu_issue_ctrl;

   localparam int W = 8;
`ifdef ALU_ISSUE_STICKY_OVF_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [2:0]   cmd_func;
   logic [W-1:0] cmd_a;
   logic [W-1:0] cmd_b;
   logic [W-1:0] alu_src1;
   logic [W-1:0] alu_src2;
   logic         alu_ainvert;
   logic         alu_binvert;
   logic [1:0]   alu_op;
   logic [W-1:0] alu_result;
   logic         alu_zero;
   logic         alu_overflow;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_result;
   logic         rsp_zero;
   logic         rsp_overflow;
   logic         rsp_err;
   logic         sticky_clr;
   logic         ovf_sticky;

   typedef struct packed {
      logic [7:0] result;
      logic       zero;
      logic       ovf;
      logic       err;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t mon_exp;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   alu_issue_ctrl #(.DATA_W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_func     (cmd_func),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .alu_src1     (alu_src1),
      .alu_src2     (alu_src2),
      .alu_ainvert  (alu_ainvert),
      .alu_binvert  (alu_binvert),
      .alu_op       (alu_op),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero),
      .alu_overflow (alu_overflow),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_zero     (rsp_zero),
      .rsp_overflow (rsp_overflow),
      .rsp_err      (rsp_err),
      .sticky_clr   (sticky_clr),
      .ovf_sticky   (ovf_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ALU: the adder always runs, so its overflow is live even for logic ops
   logic [7:0] ma, mb, ms;
   logic [8:0] msum;
   logic       movf;
   always_comb begin
      ma   = alu_ainvert ? ~alu_src1 : alu_src1;
      mb   = alu_binvert ? ~alu_src2 : alu_src2;
      msum = {1'b0, ma} + {1'b0, mb} + {8'd0, alu_binvert};
      ms   = msum[7:0];
      movf = (ma[7] == mb[7]) && (ms[7] != ma[7]);
      case (alu_op)
         2'b00:   alu_result = ma & mb;
         2'b01:   alu_result = ma | mb;
         2'b10:   alu_result = ms;
         default: alu_result = {7'd0, ms[7] ^ movf};
      endcase
      alu_zero     = (alu_result == 8'd0);
      alu_overflow = movf;
   end

   function automatic rsp_t ref_model(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
      rsp_t       r;
      logic [7:0] s;
      r = '0;
      case (f)
         3'd0: r.result = a & b;
         3'd1: r.result = a | b;
         3'd2: begin
            s = a + b;
            r.result = s;
            r.ovf = (a[7] == b[7]) && (s[7] != a[7]);
         end
         3'd3: begin
            s = a - b;
            r.result = s;
            r.ovf = (a[7] != b[7]) && (s[7] != a[7]);
         end
         3'd4: r.result = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
         3'd5: r.result = ~(a | b);
         3'd6: r.result = ~(a & b);
         default: r.err = 1'b1;
      endcase
      r.zero = !r.err && (r.result == 8'd0);
      return r;
   endfunction

   // Scoreboard: one comparison set per completed response handshake
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: got result=%h err=%b, required no response", rsp_result, rsp_err);
         end else begin
            mon_exp = exp_q.pop_front();
            checks += 3;
            if (rsp_result !== mon_exp.result) begin
               errors++;
               $display("FAIL rsp_result: got %h, required %h", rsp_result, mon_exp.result);
            end
            if (rsp_zero !== mon_exp.zero) begin
               errors++;
               $display("FAIL rsp_zero: got %b, required %b (result %h)", rsp_zero, mon_exp.zero, mon_exp.result);
            end
            if (rsp_overflow !== mon_exp.ovf) begin
               errors++;
               $display("FAIL rsp_overflow: got %b, required %b (result %h)", rsp_overflow, mon_exp.ovf, mon_exp.result);
            end
            if (rsp_err !== mon_exp.err) begin
               errors++;
               $display("FAIL rsp_err: got %b, required %b", rsp_err, mon_exp.err);
            end
         end
      end
   end

   task automatic send(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                       input bit push, output int acc_cyc);
      int n;
      n = 0;
      acc_cyc = -1;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_func  = f;
      cmd_a     = a;
      cmd_b     = b;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: cmd_ready stayed %b, required 1", cmd_ready);
      end else begin
         @(posedge clk);
         acc_cyc = cyc;
         if (push) exp_q.push_back(ref_model(f, a, b));
      end
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout: rsp_valid stayed %b, required 1", rsp_valid);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks += 6;
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b, required 0", cmd_ready); end
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
      if ({alu_src1, alu_src2, alu_ainvert, alu_binvert, alu_op} !== 20'd0) begin
         errors++; $display("FAIL reset_alu: got %h/%h/%b%b/%b, required all 0", alu_src1, alu_src2, alu_ainvert, alu_binvert, alu_op);
      end
      if ({rsp_result, rsp_zero, rsp_overflow, rsp_err} !== 11'd0) begin
         errors++; $display("FAIL reset_rsp: got %h %b%b%b, required 0", rsp_result, rsp_zero, rsp_overflow, rsp_err);
      end
      if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b, required 0", ovf_sticky); end
      rst = 1'b0;
      #1;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b, required 1", cmd_ready); end
   endtask

   task automatic test_arith;
      int acc, lat;
      logic [2:0] tf[10] = '{3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1, 3'd2, 3'd3};
      logic [7:0] ta[10] = '{8'h05, 8'h80, 8'h80, 8'h01, 8'h0F, 8'hFF, 8'h7F, 8'hC3, 8'hFF, 8'h00};
      logic [7:0] tb[10] = '{8'h05, 8'h01, 8'h01, 8'h80, 8'hF0, 8'h0F, 8'h01, 8'h0C, 8'h01, 8'h01};
      rsp_ready = 1'b1;
      send(3'd2, 8'h7F, 8'h01, 1'b1, acc);
      @(negedge clk);
      checks += 3;
      if ({alu_src1, alu_src2} !== 16'h7F01) begin errors++; $display("FAIL issue_operands: got %h %h, required 7f 01", alu_src1, alu_src2); end
      if ({alu_ainvert, alu_binvert, alu_op} !== 4'b0010) begin errors++; $display("FAIL issue_ctrl: got %b%b%b, required 0010", alu_ainvert, alu_binvert, alu_op); end
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL issue_flags: valid=%b ready=%b, required 0 0", rsp_valid, cmd_ready); end
      @(negedge clk);
      checks += 2;
      if (alu_src1 !== 8'h7F) begin errors++; $display("FAIL capture_hold: alu_src1 %h, required 7f", alu_src1); end
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL early_rsp: rsp_valid %b, required 0", rsp_valid); end
      @(negedge clk);
      checks += 2;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL latency: rsp_valid %b after 3 edges, required 1", rsp_valid); end
      if ({alu_src1, alu_op} !== 10'd0) begin errors++; $display("FAIL hold_alu_zero: got %h %b, required 0", alu_src1, alu_op); end
      @(posedge clk);
      #1;
      checks += 2;
      if (ovf_sticky !== STICKY) begin errors++; $display("FAIL sticky_set: got %b, required %b", ovf_sticky, STICKY); end
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL back_to_idle: cmd_ready %b, required 1", cmd_ready); end
      for (int i = 0; i < 10; i++) begin
         send(tf[i], ta[i], tb[i], 1'b1, acc);
         wait_rsp(lat);
         checks++;
         if (lat !== 3) begin errors++; $display("FAIL latency_%0d: got %0d, required 3", i, lat); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back;
      int acc0, acc1, lat;
      rsp_ready = 1'b1;
      send(3'd1, 8'h11, 8'h22, 1'b1, acc0);
      for (int i = 0; i < 3; i++) begin
         wait_rsp(lat);
         @(posedge clk);
         #1;
         send(3'd2, 8'(i * 40), 8'h33, 1'b1, acc1);
         checks++;
         if (acc1 - acc0 !== 4) begin errors++; $display("FAIL throughput_%0d: interval %0d, required 4", i, acc1 - acc0); end
         acc0 = acc1;
      end
      wait_rsp(lat);
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure;
      int acc, lat;
      rsp_ready = 1'b0;
      send(3'd2, 8'h01, 8'h02, 1'b1, acc);
      wait_rsp(lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks += 2;
         if ({rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_err} !== {1'b1, 8'h03, 3'b000}) begin
            errors++; $display("FAIL bp_stable_%0d: got v=%b r=%h %b%b%b, required 1 03 000", i, rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_err);
         end
         if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d: got %b, required 0", i, cmd_ready); end
         if (i == 2) begin
            cmd_valid = 1'b1; cmd_func = 3'd0; cmd_a = 8'hFF; cmd_b = 8'hFF;
         end else begin
            cmd_valid = 1'b0;
         end
      end
      cmd_valid = 1'b0;
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_release: valid=%b ready=%b, required 0 1", rsp_valid, cmd_ready); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_ignored_%0d: rsp_valid %b, required 0", i, rsp_valid); end
      end
   endtask

   task automatic test_illegal;
      int acc, lat;
      rsp_ready = 1'b1;
      send(3'd7, 8'hAA, 8'h55, 1'b1, acc);
      @(negedge clk);
      checks++;
      if ({alu_src1, alu_src2, alu_ainvert, alu_binvert, alu_op} !== 20'd0) begin
         errors++; $display("FAIL illegal_alu: got %h %h %b%b%b, required 0", alu_src1, alu_src2, alu_ainvert, alu_binvert, alu_op);
      end
      wait_rsp(lat);
      checks++;
      if (rsp_err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b, required 1", rsp_err); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_sticky;
      int acc, lat;
      rsp_ready = 1'b1;
      sticky_clr = 1'b1;
      @(posedge clk);
      #1 sticky_clr = 1'b0;
      checks++;
      if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %b, required 0", ovf_sticky); end
      send(3'd4, 8'h01, 8'h80, 1'b1, acc);
      wait_rsp(lat);
      @(posedge clk);
      #1;
      checks++;
      if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_slt: got %b, required 0", ovf_sticky); end
      send(3'd2, 8'h7F, 8'h01, 1'b1, acc);
      @(posedge clk);
      #1 sticky_clr = 1'b1;
      @(posedge clk);
      #1 sticky_clr = 1'b0;
      checks++;
      if (ovf_sticky !== STICKY) begin errors++; $display("FAIL sticky_set_wins: got %b, required %b", ovf_sticky, STICKY); end
      @(posedge clk);
      #1;
      sticky_clr = 1'b1;
      @(posedge clk);
      #1 sticky_clr = 1'b0;
      checks++;
      if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_reclear: got %b, required 0", ovf_sticky); end
   endtask

   task automatic test_reset_midflight;
      int acc, lat;
      rsp_ready = 1'b0;
      send(3'd2, 8'h7F, 8'h01, 1'b0, acc);
      wait_rsp(lat);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({rsp_valid, rsp_result, rsp_overflow, ovf_sticky} !== 11'd0) begin
         errors++; $display("FAIL reset_hold: got v=%b r=%h o=%b s=%b, required 0", rsp_valid, rsp_result, rsp_overflow, ovf_sticky);
      end
      rst = 1'b0;
      rsp_ready = 1'b1;
      send(3'd3, 8'h10, 8'h01, 1'b0, acc);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks += 3;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b, required 0", rsp_valid); end
      if ({alu_src1, alu_src2, alu_ainvert, alu_binvert, alu_op} !== 20'd0) begin
         errors++; $display("FAIL reset_issue_alu: got %h %h %b%b%b, required 0", alu_src1, alu_src2, alu_ainvert, alu_binvert, alu_op);
      end
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_issue_ready: got %b, required 0", cmd_ready); end
      rst = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_release: got %b, required 1", cmd_ready); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_discard_%0d: rsp_valid %b, required 0", i, rsp_valid); end
      end
   endtask

   initial begin
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_func   = 3'd0;
      cmd_a      = 8'd0;
      cmd_b      = 8'd0;
      rsp_ready  = 1'b0;
      sticky_clr = 1'b0;
      test_reset;
      test_arith;
      test_back_to_back;
      test_backpressure;
      test_illegal;
      test_sticky;
      test_reset_midflight;
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
